debug_dump_tx: RTL

Transmit-side companion of the debug unit's instruction loader. On a dump request it streams a fixed snapshot of processor state to the host, one byte at a time, through the existing `UART_tx` handshake (`i_tx_start` / `i_data_trama` / `o_tx_done`). It reads the register file and data memory through their debug read ports. It sits beside `UnitDebug` in the top level and shares its UART transmitter.

---
 rtl/debug_pkg.sv | 33 +++
 rtl/debug_word_serializer.sv | 37 +++
 rtl/debug_dump_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared encodings and sizing helpers for the debug dump transmitter.
package debug_pkg;

    localparam int DBG_BITS_SIZE  = 32;
    localparam int DBG_SIZE_TRAMA = 8;
    localparam int BYTES_PER_WORD = DBG_BITS_SIZE / DBG_SIZE_TRAMA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FETCH,
        ST_READ,
        ST_FINISH
    } dump_state_e;

    typedef enum logic [1:0] {
        ITEM_CNT,
        ITEM_PC,
        ITEM_REG,
        ITEM_MEM
    } item_sel_e;

    function automatic int total_bytes(input int num_regs, input int num_mem_words);
        return BYTES_PER_WORD * (2 + num_regs + num_mem_words);
    endfunction

    // A single-entry array still gets a one-bit address so ports never collapse to zero width.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Word-wide shift register emitting its MSB byte first, with a byte counter.
module debug_word_serializer #(
    parameter int BITS_SIZE  = 32,
    parameter int SIZE_TRAMA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [BITS_SIZE-1:0]  i_data,
    output logic [SIZE_TRAMA-1:0] o_byte,
    output logic                  o_last_byte
);

    localparam int BPW = BITS_SIZE / SIZE_TRAMA;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [BITS_SIZE-1:0] sreg_q;
    logic [CW-1:0]        cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_load) begin
            sreg_q <= i_data;
            cnt_q  <= '0;
        end else if (i_shift) begin
            sreg_q <= sreg_q << SIZE_TRAMA;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign o_byte      = sreg_q[BITS_SIZE-1 -: SIZE_TRAMA];
    assign o_last_byte = (cnt_q == CW'(BPW - 1));

endmodule

// File: rtl/debug_dump_tx.sv
// Streams cycle count, PC, register file and data memory to the host UART, MSB byte first.
//   state  | meaning
//   IDLE   | waiting for i_start; acceptance snapshots PC and loads the cycle count
//   SEND   | o_tx_start high for one cycle with the current byte
//   WAIT   | waiting for i_tx_done; then next byte, next item, or finish
//   FETCH  | debug read address stable for the next register/memory word
//   READ   | read data (or PC snapshot) captured into the serializer
//   FINISH | o_done pulse, o_busy already low
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int BITS_SIZE     = 32,
    parameter int SIZE_TRAMA    = 8,
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [BITS_SIZE-1:0]                 i_cycle_count,
    input  logic [BITS_SIZE-1:0]                 i_pc,
    output logic [addr_width(NUM_REGS)-1:0]      o_reg_addr,
    input  logic [BITS_SIZE-1:0]                 i_reg_data,
    output logic [addr_width(NUM_MEM_WORDS)-1:0] o_mem_addr,
    input  logic [BITS_SIZE-1:0]                 i_mem_data,
    output logic                                 o_tx_start,
    output logic [SIZE_TRAMA-1:0]                o_tx_data,
    input  logic                                 i_tx_done,
    output logic                                 o_busy,
    output logic                                 o_done
);

    localparam int RAW = addr_width(NUM_REGS);
    localparam int MAW = addr_width(NUM_MEM_WORDS);

    dump_state_e          state_q;
    item_sel_e            item_q;
    logic [RAW-1:0]       reg_addr_q;
    logic [MAW-1:0]       mem_addr_q;
    logic [BITS_SIZE-1:0] pc_snap_q;
    logic                 tx_start_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 ser_load;
    logic                 ser_shift;
    logic [BITS_SIZE-1:0] ser_din;
    logic                 ser_last;
    logic [SIZE_TRAMA-1:0] ser_byte;

    always_comb begin
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_din   = '0;
        case (state_q)
            ST_IDLE: begin
                ser_load = i_start;
                ser_din  = i_cycle_count;
            end
            ST_WAIT: ser_shift = i_tx_done && !ser_last;
            ST_READ: begin
                ser_load = 1'b1;
                case (item_q)
                    ITEM_PC:  ser_din = pc_snap_q;
                    ITEM_REG: ser_din = i_reg_data;
                    ITEM_MEM: ser_din = i_mem_data;
                    default:  ser_din = '0;
                endcase
            end
            default: ;
        endcase
    end

    debug_word_serializer #(
        .BITS_SIZE  (BITS_SIZE),
        .SIZE_TRAMA (SIZE_TRAMA)
    ) u_ser (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (ser_load),
        .i_shift     (ser_shift),
        .i_data      (ser_din),
        .o_byte      (ser_byte),
        .o_last_byte (ser_last)
    );

    // Addresses advance when a word completes, so they are already stable through FETCH.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            item_q     <= ITEM_CNT;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            pc_snap_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        pc_snap_q  <= i_pc;
                        item_q     <= ITEM_CNT;
                        reg_addr_q <= '0;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (!ser_last) begin
                            tx_start_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end else begin
                            state_q <= ST_FETCH;
                            case (item_q)
                                ITEM_CNT: item_q <= ITEM_PC;
                                ITEM_PC:  item_q <= ITEM_REG;
                                ITEM_REG: begin
                                    if (reg_addr_q == RAW'(NUM_REGS - 1)) begin
                                        item_q     <= ITEM_MEM;
                                        reg_addr_q <= '0;
                                    end else begin
                                        reg_addr_q <= reg_addr_q + RAW'(1);
                                    end
                                end
                                default: begin
                                    if (mem_addr_q == MAW'(NUM_MEM_WORDS - 1)) begin
                                        mem_addr_q <= '0;
                                        busy_q     <= 1'b0;
                                        done_q     <= 1'b1;
                                        state_q    <= ST_FINISH;
                                    end else begin
                                        mem_addr_q <= mem_addr_q + MAW'(1);
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_FETCH: state_q <= ST_READ;
                ST_READ: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_reg_addr = reg_addr_q;
    assign o_mem_addr = mem_addr_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = ser_byte;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule
